// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Drives one-cycle clock-gate enables per op class and returns results over valid/ready.

module alu_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + CNT_W'(1);
    end
endmodule

module alu_req_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_op0,
    input  logic [3:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             arith_en,
    output logic             logic_en,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] arith_cnt,
    output logic [CNT_W-1:0] logic_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t               state, state_nxt;
    req_t   [1:0]         req;
    logic                 rr;
    logic                 win;
    logic                 grant;
    logic                 is_arith, is_logic, illegal;
    logic   [1:0]         cnt_inc;
    logic   [1:0][CNT_W-1:0] cnt_q;

    assign req[0] = {req_op0, req_a0, req_b0};
    assign req[1] = {req_op1, req_a1, req_b1};

    // Grant is suppressed under reset so no requester sees a handshake that is then lost.
    always_comb begin
        win       = (req_valid == 2'b11) ? ~rr : req_valid[1];
        grant     = (state == IDLE) && (req_valid != 2'b00) && !rst;
        req_ready = 2'b00;
        if (grant)
            req_ready[win] = 1'b1;
    end

    always_comb begin
        is_arith = 1'b0;
        is_logic = 1'b0;
        case (alu_op)
            4'b0000, 4'b0001, 4'b0111: is_arith = 1'b1;
            4'b0010, 4'b0011, 4'b0100: is_logic = 1'b1;
            default: ;
        endcase
        illegal = !(is_arith || is_logic);
    end

    always_comb begin
        state_nxt = state;
        arith_en  = 1'b0;
        logic_en  = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: if (grant) state_nxt = EXEC;
            EXEC: begin
                arith_en  = is_arith;
                logic_en  = is_logic;
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers only load on a grant so the ALU inputs stay quiet while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rr       <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            if (grant) begin
                rr     <= win;
                alu_op <= req[win].op;
                alu_a  <= req[win].a;
                alu_b  <= req[win].b;
                rsp_id <= win;
            end
            if (state == EXEC) begin
                rsp_data <= illegal ? '0 : alu_result;
                rsp_err  <= illegal;
            end
        end
    end

    assign cnt_inc = {logic_en, arith_en};

    for (genvar g = 0; g < 2; g++) begin : g_cnt
        alu_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (cnt_inc[g]),
            .cnt (cnt_q[g])
        );
    end

    assign arith_cnt = cnt_q[0];
    assign logic_cnt = cnt_q[1];
endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: transaction-level model checked every cycle, plus directed
// literal checks. A second instance with 2-bit counters exercises saturation.

module tb_alu_req_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [3:0] req_op0 = '0, req_op1 = '0;
    logic [7:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic       rsp_ready = 1'b0;

    logic [1:0]  req_ready, req_ready_s;
    logic [3:0]  alu_op, alu_op_s;
    logic [7:0]  alu_a, alu_b, alu_a_s, alu_b_s, alu_result, alu_result_s;
    logic        arith_en, logic_en, rsp_valid, rsp_id, rsp_err, busy;
    logic        arith_en_s, logic_en_s, rsp_valid_s, rsp_id_s, rsp_err_s, busy_s;
    logic [7:0]  rsp_data, rsp_data_s;
    logic [15:0] arith_cnt, logic_cnt;
    logic [1:0]  arith_cnt_s, logic_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h7: return a + b + 8'd1;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // 1 = arithmetic, 2 = logic, 0 = illegal
    function automatic int op_class(logic [3:0] op);
        if (op == 4'h0 || op == 4'h1 || op == 4'h7) return 1;
        if (op >= 4'h2 && op <= 4'h4) return 2;
        return 0;
    endfunction

    assign alu_result   = alu_fn(alu_op, alu_a, alu_b);
    assign alu_result_s = alu_fn(alu_op_s, alu_a_s, alu_b_s);

    alu_req_scheduler #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .arith_en(arith_en), .logic_en(logic_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .arith_cnt(arith_cnt), .logic_cnt(logic_cnt)
    );

    alu_req_scheduler #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_b0(req_b0),
        .req_a1(req_a1), .req_b1(req_b1), .alu_op(alu_op_s), .alu_a(alu_a_s), .alu_b(alu_b_s),
        .alu_result(alu_result_s), .arith_en(arith_en_s), .logic_en(logic_en_s),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_id(rsp_id_s), .rsp_data(rsp_data_s),
        .rsp_err(rsp_err_s), .busy(busy_s), .arith_cnt(arith_cnt_s), .logic_cnt(logic_cnt_s)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding op, timestamped by its grant cycle.
    int         cyc = 0, tg = 0, acnt = 0, lcnt = 0;
    bit         have = 0, mready = 0, mrr = 0, mid = 0, merr = 0;
    logic [3:0] mop = '0;
    logic [7:0] ma = '0, mb = '0, mdata = '0;

    always @(negedge clk) begin
        bit idle, ex, rs, w;
        logic [1:0] er;
        int sat16, sat2a, sat2l;
        idle = !have;
        ex   = have && (cyc == tg + 1);
        rs   = have && (cyc >= tg + 2);
        w    = (req_valid == 2'b11) ? !mrr : req_valid[1];
        er   = (idle && !rst && req_valid != 2'b00) ? (w ? 2'b10 : 2'b01) : 2'b00;
        if (mready) begin
            sat16 = (acnt > 65535) ? 65535 : acnt;
            sat2a = (acnt > 3) ? 3 : acnt;
            sat2l = (lcnt > 3) ? 3 : lcnt;
            check("req_ready", 32'(req_ready), 32'(er));
            check("busy", 32'(busy), 32'(have));
            check("arith_en", 32'(arith_en), 32'(ex && op_class(mop) == 1));
            check("logic_en", 32'(logic_en), 32'(ex && op_class(mop) == 2));
            check("rsp_valid", 32'(rsp_valid), 32'(rs));
            check("rsp_id", 32'(rsp_id), 32'(mid));
            check("rsp_data", 32'(rsp_data), 32'(mdata));
            check("rsp_err", 32'(rsp_err), 32'(merr));
            check("alu_opnd", {20'b0, alu_op, alu_a}, {20'b0, mop, ma});
            check("alu_b", 32'(alu_b), 32'(mb));
            check("arith_cnt", 32'(arith_cnt), 32'(sat16));
            check("logic_cnt", 32'(logic_cnt), 32'((lcnt > 65535) ? 65535 : lcnt));
            check("s_req_ready", 32'(req_ready_s), 32'(er));
            check("s_outs", {26'b0, busy_s, arith_en_s, logic_en_s, rsp_valid_s, rsp_id_s, rsp_err_s},
                  {26'b0, have, ex && op_class(mop) == 1, ex && op_class(mop) == 2, rs, mid, merr});
            check("s_rsp_data", 32'(rsp_data_s), 32'(mdata));
            check("s_arith_cnt", 32'(arith_cnt_s), 32'(sat2a));
            check("s_logic_cnt", 32'(logic_cnt_s), 32'(sat2l));
        end
        if (rst) begin
            have = 0; mrr = 0; mid = 0; merr = 0; mop = '0; ma = '0; mb = '0; mdata = '0;
            acnt = 0; lcnt = 0; mready = 1;
        end else begin
            if (ex) begin
                merr  = (op_class(mop) == 0);
                mdata = merr ? 8'h00 : alu_fn(mop, ma, mb);
                if (op_class(mop) == 1) acnt++;
                if (op_class(mop) == 2) lcnt++;
            end
            if (rs && rsp_ready) have = 0;
            if (er != 2'b00) begin
                have = 1; tg = cyc; mrr = w; mid = w;
                mop  = w ? req_op1 : req_op0;
                ma   = w ? req_a1 : req_a0;
                mb   = w ? req_b1 : req_b0;
            end
        end
        cyc++;
    end

    function automatic logic [3:0] pick_op(int mode);
        logic [3:0] arith_ops [3];
        arith_ops[0] = 4'h0; arith_ops[1] = 4'h1; arith_ops[2] = 4'h7;
        case (mode)
            1: return arith_ops[$urandom_range(2)];
            2: return 4'($urandom_range(4, 2));
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        logic [1:0] took;
        int pv, pr;
        bit arith_seen, hit;
        logic grants [$];
        logic exp_g [4];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_arith_cnt", 32'(arith_cnt), 32'd0);

        // Single add from requester 0: 5 + 3
        @(posedge clk); #1;
        req_valid = 2'b01; req_op0 = 4'h0; req_a0 = 8'h05; req_b0 = 8'h03; rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("add_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk); #1;
        check("add_en", {30'b0, arith_en, logic_en}, 32'h2);
        @(negedge clk); #1;
        check("add_rsp", {22'b0, rsp_valid, rsp_id, rsp_err, rsp_data}, {22'b0, 3'b100, 8'h08});
        check("add_cnt", 32'(arith_cnt), 32'd1);
        check("add_cnt_s", 32'(arith_cnt_s), 32'd1);

        // Both requesters continuously valid with logic ops: grants must alternate
        @(posedge clk); #1;
        req_valid = 2'b11; req_op0 = 4'h2; req_op1 = 4'h2;
        req_a0 = 8'hF0; req_b0 = 8'h3C; req_a1 = 8'h0F; req_b1 = 8'hAA;
        arith_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); #1;
            if (req_ready != 2'b00) grants.push_back(req_ready[1]);
            if (arith_en) arith_seen = 1;
            if (k == 11) check("rr_logic_cnt", 32'(logic_cnt), 32'd4);
            if (k < 11) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1 req_valid = 2'b00;
        exp_g[0] = 1'b1; exp_g[1] = 1'b0; exp_g[2] = 1'b1; exp_g[3] = 1'b0;
        check("rr_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check("rr_grant_id", 32'(grants[i]), 32'(exp_g[i]));
        check("rr_no_arith_en", 32'(arith_seen), 32'd0);

        // Illegal opcode from requester 1 while the response is back-pressured
        @(posedge clk); #1;
        req_valid = 2'b11; req_op1 = 4'hF; req_op0 = 4'h1; req_a0 = 8'h09; req_b0 = 8'h04;
        rsp_ready = 1'b0;
        @(negedge clk); #1;
        check("ill_req_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1 req_valid = 2'b01;
        @(negedge clk); #1;
        check("ill_no_en", {30'b0, arith_en, logic_en}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("hold_rsp", {21'b0, req_ready, rsp_valid, rsp_id, rsp_err, rsp_data},
                  {21'b0, 2'b00, 3'b111, 8'h00});
            check("hold_cnts", {arith_cnt, logic_cnt}, {16'd1, 16'd4});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("accept_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("next_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Randomised traffic across opcode mixes and back-pressure rates
        for (int m = 0; m < 4; m++) begin
            pv = (m == 3) ? 95 : 60;
            pr = (m == 0) ? 90 : 50;
            repeat (600) begin
                @(negedge clk); took = req_ready;
                @(posedge clk); #1;
                for (int i = 0; i < 2; i++) begin
                    if (took[i] || !req_valid[i]) begin
                        req_valid[i] = ($urandom_range(99) < pv);
                        if (i == 0) begin
                            req_op0 = pick_op(m); req_a0 = 8'($urandom); req_b0 = 8'($urandom);
                        end else begin
                            req_op1 = pick_op(m); req_a1 = 8'($urandom); req_b1 = 8'($urandom);
                        end
                    end
                end
                rsp_ready = ($urandom_range(99) < pr);
            end
        end
        req_valid = 2'b00; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("sat_logic_cnt", 32'(logic_cnt_s), 32'd3);

        // Reset while a response is pending
        rsp_ready = 1'b0; req_valid = 2'b01; req_op0 = 4'h0;
        @(negedge clk);
        @(posedge clk); #1 req_valid = 2'b00;
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk); #1;
            if (rsp_valid) hit = 1;
        end
        check("reach_resp", 32'(hit), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_outs", {25'b0, rsp_valid, busy, arith_en, logic_en, rsp_id, rsp_err, req_ready == 2'b00},
              {25'b0, 7'b0000001});
        check("rst_mid_data", {12'b0, alu_op, alu_a, rsp_data}, 32'd0);
        check("rst_mid_cnts", {arith_cnt, logic_cnt}, 32'd0);
        check("rst_mid_cnts_s", {28'b0, arith_cnt_s, logic_cnt_s}, 32'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one combinational ALU datapath between two requesters, using round-robin arbitration.
- Registers each granted operation and drives the ALU operands.
- Raises the arithmetic or logic clock-gate enable for exactly one cycle per operation, so each gated domain toggles only when used.
- Captures the ALU result and returns it to the winning requester on a valid/ready response channel; keeps saturating per-class activity counters for power profiling.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CNT_W, 16, width of each activity counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  2  per-requester request valid; bit i is requester i.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_op0, req_op1  in  4 each  opcode from requester 0 / 1.
- req_a0, req_b0, req_a1, req_b1  in  WIDTH each  operands.
- alu_op  out  4  opcode driven to the ALU.
- alu_a, alu_b  out  WIDTH each  operands driven to the ALU.
- alu_result  in  WIDTH  combinational ALU result.
- arith_en  out  1  enable for the arithmetic clock-gating cell.
- logic_en  out  1  enable for the logic clock-gating cell.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  WIDTH  captured result.
- rsp_err  out  1  illegal opcode flag.
- busy  out  1  high whenever the FSM is not in IDLE.
- arith_cnt, logic_cnt  out  CNT_W each  saturating counts of issued arithmetic / logic ops.

Behaviour:
- Reset (rst=1 at a clk edge) returns all of the following to zero; it overrides any operation in flight, and a pending response is dropped:
  - FSM state to IDLE, rr pointer to 0.
  - req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, arith_en, logic_en, busy.
  - alu_op, alu_a, alu_b registers, arith_cnt, logic_cnt.
- Opcode classes:
  - arithmetic = 4'b0000, 4'b0001, 4'b0111;
  - logic = 4'b0010 to 4'b0100;
  - every other opcode is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE behaviour:
  - If req_valid != 0, grant one requester and assert its req_ready combinationally in the same cycle; the handshake completes in that cycle.
  - Register the winner's op/a/b into alu_op/alu_a/alu_b and its index as rsp_id, then go to EXEC.
  - If req_valid == 0, stay in IDLE with req_ready=0.
- Arbitration:
  - With one valid requester, that requester wins.
  - With both valid, the requester != rr pointer wins.
  - The rr pointer updates to the winner's index on every grant.
  - Example: pointer 0 and both valid, so requester 1 wins, then pointer=1.
- EXEC state (exactly one cycle):
  - alu_op/a/b stay stable.
  - arith_en=1 iff the class is arithmetic; logic_en=1 iff the class is logic; both are 0 for illegal opcodes.
  - Both enables are 0 in every other state, so they are never high together.
  - At the end of EXEC:
    - rsp_data <= alu_result, or 0 if the opcode is illegal; rsp_err <= illegal.
    - The matching counter increments by 1 and saturates at 2^CNT_W-1.
  - Next state is RESP.
- RESP state:
  - rsp_valid=1; rsp_data/rsp_id/rsp_err are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - No new grant is issued in the same cycle; req_ready=0 in EXEC and RESP.
- Latency and throughput:
  - Grant at cycle N, arith_en/logic_en at N+1, rsp_valid at N+2.
  - Minimum spacing is 3 cycles per operation.
- Requests are level-held by requesters until their req_ready; a deasserted req_valid is never granted.
- busy = (state != IDLE), registered alongside the state.
- alu_op/a/b retain their last values in IDLE, so the datapath inputs do not toggle.

Test Plan:
- Reset with rsp_valid high mid-RESP -> next cycle all outputs 0, state IDLE, rsp_valid=0, counters 0.
- Requester 0 only: op=0000, a=8'h05, b=8'h03, ALU model add, rsp_ready=1 -> req_ready[0] at N; arith_en=1 and logic_en=0 at N+1; at N+2 rsp_valid=1, rsp_data=8'h08, rsp_id=0, rsp_err=0; arith_cnt=1.
- Both requesters valid continuously, both op=0010 -> grants alternate 1,0,1,0 every 3 cycles; logic_en pulses once per op; logic_cnt=4 after four ops; arith_en never high.
- Illegal op=1111 from requester 1 -> no enable pulse; rsp_data=0, rsp_err=1, rsp_id=1; counters unchanged.
- rsp_ready held low 5 cycles in RESP with req_valid=2'b11 -> rsp_valid/rsp_data stable, req_ready=0 throughout; after accept, IDLE grants the next requester.
- CNT_W=2, five arithmetic ops -> arith_cnt reads 1,2,3,3,3 (saturation, no wrap).
